// File: rtl/filter_pkg.sv
// Shared constants for the 3x3 filter front end: default pixel width and window indexing.
package filter_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned WIN_DIM    = 3;
  localparam int unsigned WIN_SIZE   = WIN_DIM * WIN_DIM;

  // 1-based, row-major from the top-left tap
  localparam int unsigned WIN_TOP_LEFT = 1;
  localparam int unsigned WIN_CENTRE   = 5;
  localparam int unsigned WIN_BOT_RIGHT = 9;

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: synchronous write, combinational read at the same address.
module line_buffer #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/line_window_3x3.sv
// Raster-scan 3x3 sliding window generator with two line buffers.
// Optional frame_done output is enabled by defining FRAME_DONE_EN.
module line_window_3x3
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] sw_pixel_1,
  output logic [DATA_W-1:0] sw_pixel_2,
  output logic [DATA_W-1:0] sw_pixel_3,
  output logic [DATA_W-1:0] sw_pixel_4,
  output logic [DATA_W-1:0] sw_pixel_5,
  output logic [DATA_W-1:0] sw_pixel_6,
  output logic [DATA_W-1:0] sw_pixel_7,
  output logic [DATA_W-1:0] sw_pixel_8,
  output logic [DATA_W-1:0] sw_pixel_9,
  output logic              act
`ifdef FRAME_DONE_EN
  ,
  output logic              frame_done
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]     col_q, col_d, pos_c;
  logic [RW-1:0]     row_q, row_d, pos_r;
  logic [DATA_W-1:0] win_q [WIN_SIZE];
  logic [DATA_W-1:0] win_d [WIN_SIZE];
  logic [DATA_W-1:0] sw_q  [WIN_SIZE];
  logic [DATA_W-1:0] sw_d  [WIN_SIZE];
  logic              act_q, act_d;
  logic [DATA_W-1:0] lb0_dout, lb1_dout;
`ifdef FRAME_DONE_EN
  logic              fd_q, fd_d;
`endif

  // LB0 holds the previous row; LB1 takes LB0's old value, i.e. two rows back
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk  (clk),
    .we   (pix_valid),
    .addr (pos_c),
    .din  (pix_in),
    .dout (lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .we   (pix_valid),
    .addr (pos_c),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  always_comb begin
    pos_c = col_q;
    pos_r = row_q;
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    sw_d  = sw_q;
    act_d = 1'b0;
`ifdef FRAME_DONE_EN
    fd_d  = 1'b0;
`endif
    // sof forces the accepted pixel to the frame origin
    if (pix_valid && sof) begin
      pos_c = '0;
      pos_r = '0;
    end
    if (pix_valid) begin
      if (pos_c == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pos_r == RW'(IMG_H - 1)) ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_dout;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_dout;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      act_d = (pos_r >= RW'(2)) && (pos_c >= CW'(2));
      // Outputs only move when a valid window is presented
      if (act_d) sw_d = win_d;
`ifdef FRAME_DONE_EN
      fd_d = (pos_c == CW'(IMG_W - 1)) && (pos_r == RW'(IMG_H - 1));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      sw_q  <= '{default: '0};
      act_q <= 1'b0;
`ifdef FRAME_DONE_EN
      fd_q  <= 1'b0;
`endif
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      sw_q  <= sw_d;
      act_q <= act_d;
`ifdef FRAME_DONE_EN
      fd_q  <= fd_d;
`endif
    end
  end

  assign sw_pixel_1 = sw_q[WIN_TOP_LEFT - 1];
  assign sw_pixel_2 = sw_q[1];
  assign sw_pixel_3 = sw_q[2];
  assign sw_pixel_4 = sw_q[3];
  assign sw_pixel_5 = sw_q[WIN_CENTRE - 1];
  assign sw_pixel_6 = sw_q[5];
  assign sw_pixel_7 = sw_q[6];
  assign sw_pixel_8 = sw_q[7];
  assign sw_pixel_9 = sw_q[WIN_BOT_RIGHT - 1];
  assign act        = act_q;
`ifdef FRAME_DONE_EN
  assign frame_done = fd_q;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on an 8x4 frame with pixel = row*16+col.
module tb_line_window_3x3;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5;
  logic [7:0] sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9;
  logic       act;
`ifdef FRAME_DONE_EN
  logic       frame_done;
`endif

  line_window_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .sw_pixel_1 (sw_pixel_1),
    .sw_pixel_2 (sw_pixel_2),
    .sw_pixel_3 (sw_pixel_3),
    .sw_pixel_4 (sw_pixel_4),
    .sw_pixel_5 (sw_pixel_5),
    .sw_pixel_6 (sw_pixel_6),
    .sw_pixel_7 (sw_pixel_7),
    .sw_pixel_8 (sw_pixel_8),
    .sw_pixel_9 (sw_pixel_9),
    .act        (act)
`ifdef FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acts   = 0;
  int          mr     = 0;
  int          mc     = 0;
  logic [7:0]  img [IMG_H][IMG_W];
  logic [71:0] sb [$];
  logic [71:0] hold = '0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] win_out();
    return {sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
            sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9};
  endfunction

  task automatic model_reset();
    mr = 0;
    mc = 0;
    sb.delete();
    hold = '0;
  endtask

  // One clock: drive, update the model, then compare what the DUT presents
  task automatic step(input bit v, input bit s);
    bit          ea;
    bit          efd;
    int          pr;
    int          pc;
    logic [71:0] ew;
    logic [71:0] got;
    ea  = 1'b0;
    efd = 1'b0;
    pr  = -1;
    pc  = -1;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      pr = mr;
      pc = mc;
      pix_in = 8'(pr * 16 + pc);
      img[pr][pc] = pix_in;
      if (pr >= 2 && pc >= 2) begin
        ea = 1'b1;
        sb.push_back({img[pr-2][pc-2], img[pr-2][pc-1], img[pr-2][pc],
                      img[pr-1][pc-2], img[pr-1][pc-1], img[pr-1][pc],
                      img[pr][pc-2],   img[pr][pc-1],   img[pr][pc]});
      end
      efd = (pr == IMG_H - 1) && (pc == IMG_W - 1);
      if (mc == IMG_W - 1) begin
        mc = 0;
        mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
      sof = s;
    end else begin
      pix_in = 8'($urandom);
      sof    = 1'($urandom);
    end
    pix_valid = v;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    got = win_out();
    check("act", 72'(act), 72'(ea));
    if (act === 1'b1) begin
      acts++;
      if (sb.size() != 0) begin
        ew = sb.pop_front();
        check("win", got, ew);
        hold = ew;
      end else begin
        check("sb_depth", 72'(sb.size()), 72'd1);
      end
    end else begin
      check("hold", got, hold);
      sb.delete();
    end
    if (v && pr == 2 && pc == 2) check("win22", got, 72'h000102101112202122);
    if (v && pr == 2 && pc == 5) check("centre14", 72'(sw_pixel_5), 72'h14);
    if (v && pr == 3 && pc == 7) check("centre26", 72'(sw_pixel_5), 72'h26);
`ifdef FRAME_DONE_EN
    check("frame_done", 72'(frame_done), 72'(efd));
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_act", 72'(act), 72'd0);
    check("rst_win", win_out(), 72'd0);
`ifdef FRAME_DONE_EN
    check("rst_fd", 72'(frame_done), 72'd0);
`endif
    rst_n = 1'b1;

    // Continuous frame
    acts = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) step(1'b1, i == 0);
    check("acts_cont", 72'(acts), 72'd12);

    // Three idle cycles between (4,2) and (5,2)
    acts = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      step(1'b1, i == 0);
      if (i == 2 * IMG_W + 4) repeat (3) step(1'b0, 1'b0);
    end
    check("acts_gap", 72'(acts), 72'd12);

    // sof re-asserted at (3,1) restarts the frame
    acts = 0;
    for (int i = 0; i < IMG_W + 3; i++) step(1'b1, i == 0);
    step(1'b1, 1'b1);
    for (int i = 1; i < IMG_W * IMG_H; i++) step(1'b1, 1'b0);
    check("acts_resof", 72'(acts), 72'd12);

    // Asynchronous reset just after (5,2) was accepted
    for (int i = 0; i <= 2 * IMG_W + 5; i++) step(1'b1, i == 0);
    rst_n = 1'b0;
    #1;
    check("midrst_act", 72'(act), 72'd0);
    check("midrst_win", win_out(), 72'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acts = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) step(1'b1, i == 0);
    check("acts_postrst", 72'(acts), 72'd12);

    // Random idle gaps, including noise on sof while invalid
    acts = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0);
      step(1'b1, i == 0);
    end
    check("acts_rand", 72'(acts), 72'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per line (min 3).
REQ-002 SHALL have parameter IMG_H, default 256, lines per frame (min 3).
REQ-003 SHALL have parameter DATA_W, default 8, pixel width.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port pix_in, input, DATA_W, raster-order input pixel.
REQ-007 SHALL have port pix_valid, input, 1, pix_in accepted this cycle.
REQ-008 SHALL have port sof, input, 1, start of frame, qualified by pix_valid.
REQ-009 SHALL have ports sw_pixel_1..sw_pixel_9, output, DATA_W each, 3x3 window, row-major from top-left; sw_pixel_5 is the centre.
REQ-010 SHALL have port act, output, 1, window valid strobe for the downstream filter.

Function
REQ-011 SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) for the position of the next accepted pixel.
REQ-012 SHALL leave counters, line buffers and window unchanged in cycles with pix_valid=0.
REQ-013 SHALL keep two line buffers, each IMG_W deep, addressed by column: LB0 holds row r-1 and LB1 holds row r-2.
REQ-014 SHALL, on accept at column c: LB1[c]<=LB0[c], LB0[c]<=pix_in; line buffer read is combinational at address c.
REQ-015 SHALL, on accept, shift the window one column left and load the right column with {LB1[c], LB0[c], pix_in}, top to bottom.
REQ-016 SHALL assert act for exactly one cycle, the cycle after accepting a pixel at row>=2 and col>=2; latency 1 cycle.
REQ-017 SHALL, while act=1, present the window centred on (row-1, col-1) of that accepted pixel; only interior centres produce act, (IMG_W-2)*(IMG_H-2) strobes per frame.
REQ-018 SHALL hold sw_pixel_* stable when act=0; downstream ignores their value.
REQ-019 SHALL wrap the column at IMG_W-1 to 0 and increment the row; at (IMG_W-1, IMG_H-1) both counters wrap to 0.
REQ-020 SHALL treat an accepted pixel with sof=1 as position (0,0), regardless of the counters; counters then continue from (1,0); window and line buffer contents are not cleared.
REQ-021 SHALL ignore sof when pix_valid=0.
REQ-022 SHALL accept one pixel per cycle with no backpressure; no stall input.

Reset
REQ-023 SHALL, on rst_n low, clear counters, act, all sw_pixel_* and window registers to 0, asynchronously, including mid-frame.
REQ-024 SHALL not require line buffer clearing on reset; after reset the first frame rows 0-1 refill them before any act.

Configuration
REQ-025 SHALL, with FRAME_DONE_EN defined, add output frame_done (1 bit, reset 0), pulsing one cycle after accepting pixel (IMG_W-1, IMG_H-1), coincident with the last act of the frame.
REQ-026 SHALL, without FRAME_DONE_EN, omit the frame_done port and logic; all other behaviour identical.

Structure
REQ-027 SHALL place the DATA_W default and the window index constants (centre index 5) in shared package filter_pkg.
REQ-028 SHALL implement each line buffer as sub-module line_buffer (parameters DEPTH, DATA_W; ports clk, we, addr, din, dout), instantiated twice.

Verification
REQ-029 SHALL cover: IMG_W=8, IMG_H=4, pixel=row*16+col, continuous valid, sof on first -> cycle after (2,2) act=1, window 00,01,02,10,11,12,20,21,22.
REQ-030 SHALL cover: same frame -> exactly 12 act pulses; none after pixels at row<2 or col<2.
REQ-031 SHALL cover: pix_valid low 3 cycles between (4,2) and (5,2) -> act low, outputs held; after (5,2) window centre 0x14.
REQ-032 SHALL cover: sof reasserted at (3,1) -> that pixel treated as (0,0); no act until the new row 2 col 2.
REQ-033 SHALL cover: rst_n low at (5,2) -> act and outputs 0 immediately; next frame after sof gives the REQ-029 window correctly.
REQ-034 SHALL cover: FRAME_DONE_EN defined -> frame_done=1 only in the cycle after (7,3), together with act, window centre 0x26.
